// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter and sequencer that shares one external combinational
// 32-bit ALU between NUM_REQ requesters. One operation is in flight at a time:
// accept -> drive ALU from registered operands -> capture -> respond.
//
// Optional build macro: ALU_ARB_PERF_CNT_EN
//   When defined, adds PERF_CNT_o (saturating count of response handshakes)
//   and PERF_ERR_o (sticky flag, set by any response carrying ERR).
//
// state | meaning
// IDLE  | no operation held; REQ_READY_o grants the round-robin winner
// EXEC  | captured operands drive the ALU; result/zero sampled at cycle end
// RESP  | result presented to the granted requester until it accepts
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    REQ_VALID_i,
    output logic [NUM_REQ-1:0]    REQ_READY_o,
    input  logic [4*NUM_REQ-1:0]  REQ_OP_i,
    input  logic [32*NUM_REQ-1:0] REQ_RS1_i,
    input  logic [32*NUM_REQ-1:0] REQ_RS2_i,
    output logic [NUM_REQ-1:0]    RSP_VALID_o,
    input  logic [NUM_REQ-1:0]    RSP_READY_i,
    output logic [31:0]           RSP_RD_o,
    output logic                  RSP_ZR_o,
    output logic                  RSP_ERR_o,
    output logic [3:0]            ALU_OP_o,
    output logic [31:0]           ALU_RS1_o,
    output logic [31:0]           ALU_RS2_o,
    input  logic [31:0]           ALU_RD_i,
    input  logic                  ALU_ZR_i,
`ifdef ALU_ARB_PERF_CNT_EN
    output logic [15:0]           PERF_CNT_o,
    output logic                  PERF_ERR_o,
`endif
    output logic                  BUSY_o
);

    // The ALU produces X for these opcodes, so its outputs are never sampled.
    localparam logic [3:0] OP_UNDEF_A = 4'b0110;
    localparam logic [3:0] OP_UNDEF_B = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   last_grant_q, last_grant_d;
    logic [31:0]        rd_q, rd_d;
    logic               zr_q, zr_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic [PTR_W-1:0]   cand;
    logic [3:0]         sel_op;
    logic [31:0]        sel_rs1;
    logic [31:0]        sel_rs2;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!pick_any && REQ_VALID_i[cand]) begin
                pick_any      = 1'b1;
                pick_idx      = cand;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    // Payload of the winning requester, selected by the one-hot pick.
    always_comb begin
        sel_op  = '0;
        sel_rs1 = '0;
        sel_rs2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) begin
                sel_op  = REQ_OP_i[4*k +: 4];
                sel_rs1 = REQ_RS1_i[32*k +: 32];
                sel_rs2 = REQ_RS2_i[32*k +: 32];
            end
        end
    end

    // Next-state and datapath capture; ready/valid are decoded from state.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rd_d         = rd_q;
        zr_d         = zr_q;
        err_d        = err_q;
        req_ready    = '0;
        rsp_valid    = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = pick_oh;
                if (pick_any) begin
                    op_d    = sel_op;
                    rs1_d   = sel_rs1;
                    rs2_d   = sel_rs2;
                    grant_d = pick_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_UNDEF_A || op_q == OP_UNDEF_B) begin
                    rd_d  = '0;
                    zr_d  = 1'b0;
                    err_d = 1'b1;
                end else begin
                    rd_d  = ALU_RD_i;
                    zr_d  = ALU_ZR_i;
                    err_d = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                // Only the granted requester's ready bit matters.
                if (RSP_READY_i[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= PTR_W'(NUM_REQ - 1);
            rd_q         <= '0;
            zr_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rd_q         <= rd_d;
            zr_q         <= zr_d;
            err_q        <= err_d;
        end
    end

    assign REQ_READY_o = req_ready;
    assign RSP_VALID_o = rsp_valid;
    assign RSP_RD_o    = rd_q;
    assign RSP_ZR_o    = zr_q;
    assign RSP_ERR_o   = err_q;
    assign ALU_OP_o    = op_q;
    assign ALU_RS1_o   = rs1_q;
    assign ALU_RS2_o   = rs2_q;
    assign BUSY_o      = (state_q != ST_IDLE);

`ifdef ALU_ARB_PERF_CNT_EN
    logic        rsp_hs;
    logic [15:0] perf_cnt_q, perf_cnt_d;
    logic        perf_err_q, perf_err_d;

    assign rsp_hs = (state_q == ST_RESP) && RSP_READY_i[grant_q];

    // Saturating response counter and sticky error flag.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        perf_err_d = perf_err_q;
        if (rsp_hs) begin
            if (perf_cnt_q != 16'hFFFF) begin
                perf_cnt_d = perf_cnt_q + 16'd1;
            end
            if (err_q) begin
                perf_err_d = 1'b1;
            end
        end
    end

    // Performance registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
            perf_err_q <= 1'b0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_err_q <= perf_err_d;
        end
    end

    assign PERF_CNT_o = perf_cnt_q;
    assign PERF_ERR_o = perf_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic, with a
// scoreboard monitor that predicts grants, latency and responses.
module tb_alu_arbiter;

    localparam int N = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [4*N-1:0]  req_op;
    logic [32*N-1:0] req_rs1;
    logic [32*N-1:0] req_rs2;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_rd;
    logic            rsp_zr;
    logic            rsp_err;
    logic [3:0]      alu_op;
    logic [31:0]     alu_rs1;
    logic [31:0]     alu_rs2;
    logic [31:0]     alu_rd;
    logic            alu_zr;
    logic            busy;
`ifdef ALU_ARB_PERF_CNT_EN
    logic [15:0]     perf_cnt;
    logic            perf_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .REQ_VALID_i (req_valid),
        .REQ_READY_o (req_ready),
        .REQ_OP_i    (req_op),
        .REQ_RS1_i   (req_rs1),
        .REQ_RS2_i   (req_rs2),
        .RSP_VALID_o (rsp_valid),
        .RSP_READY_i (rsp_ready),
        .RSP_RD_o    (rsp_rd),
        .RSP_ZR_o    (rsp_zr),
        .RSP_ERR_o   (rsp_err),
        .ALU_OP_o    (alu_op),
        .ALU_RS1_o   (alu_rs1),
        .ALU_RS2_o   (alu_rs2),
        .ALU_RD_i    (alu_rd),
        .ALU_ZR_i    (alu_zr),
`ifdef ALU_ARB_PERF_CNT_EN
        .PERF_CNT_o  (perf_cnt),
        .PERF_ERR_o  (perf_err),
`endif
        .BUSY_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the shared ALU; undefined opcodes give garbage.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a ^ b;
            4'h4: return a << b[4:0];
            4'h5: return a >> b[4:0];
            4'h6, 4'hB: return 32'hDEAD_BEEF;
            4'h7: return {31'd0, a < b};
            4'h8: return 32'($signed(a) >>> b[4:0]);
            4'hA: return a - b;
            4'hC: return {31'd0, $signed(a) < $signed(b)};
            default: return ~a;
        endcase
    endfunction

    assign alu_rd = alu_f(alu_op, alu_rs1, alu_rs2);
    assign alu_zr = (alu_op == 4'h6 || alu_op == 4'hB) ? 1'b1 : (alu_rd == 32'd0);

    typedef struct {
        int          k;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;
        logic        zr;
        logic        err;
        int          hs;
    } txn_t;

    txn_t q[$];
    int   last_g = N - 1;
    int   m_cnt  = 0;
    logic m_err  = 1'b0;

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
        int j;
        for (int i = 1; i <= N; i++) begin
            j = (last + i) % N;
            if (v[j]) return onehot(j);
        end
        return '0;
    endfunction

    function automatic txn_t make_txn(input int k, input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input int hs);
        txn_t t;
        t.k  = k;
        t.op = op;
        t.a  = a;
        t.b  = b;
        t.hs = hs;
        if (op == 4'b0110 || op == 4'b1011) begin
            t.rd  = 32'd0;
            t.zr  = 1'b0;
            t.err = 1'b1;
        end else begin
            t.rd  = alu_f(op, a, b);
            t.zr  = (t.rd == 32'd0);
            t.err = 1'b0;
        end
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: predicts ready/busy/valid each cycle and pops on response handshake.
    logic [N-1:0] m_er, m_ev;
    int           m_k;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            last_g = N - 1;
            m_cnt  = 0;
            m_err  = 1'b0;
        end else begin
            m_er = (q.size() == 0) ? rr_pick(req_valid, last_g) : '0;
            m_ev = '0;
            if (q.size() != 0 && cyc >= q[0].hs + 2) m_ev = onehot(q[0].k);
            chk("mon_req_ready", 32'(req_ready), 32'(m_er));
            chk("mon_busy", 32'(busy), 32'(q.size() != 0));
            chk("mon_rsp_valid", 32'(rsp_valid), 32'(m_ev));
            if (m_ev != '0) begin
                chk("mon_rsp_rd", rsp_rd, q[0].rd);
                chk("mon_rsp_zr", 32'(rsp_zr), 32'(q[0].zr));
                chk("mon_rsp_err", 32'(rsp_err), 32'(q[0].err));
            end
            if (q.size() != 0 && cyc == q[0].hs + 1) begin
                chk("mon_alu_op", 32'(alu_op), 32'(q[0].op));
                chk("mon_alu_rs1", alu_rs1, q[0].a);
                chk("mon_alu_rs2", alu_rs2, q[0].b);
            end
`ifdef ALU_ARB_PERF_CNT_EN
            chk("mon_perf_cnt", 32'(perf_cnt), 32'(m_cnt));
            chk("mon_perf_err", 32'(perf_err), 32'(m_err));
`endif
            if (m_ev != '0 && rsp_ready[q[0].k]) begin
                last_g = q[0].k;
                if (m_cnt < 65535) m_cnt++;
                m_err = m_err | q[0].err;
                void'(q.pop_front());
            end else if (m_er != '0) begin
                m_k = 0;
                for (int i = 0; i < N; i++) if (m_er[i]) m_k = i;
                q.push_back(make_txn(m_k, req_op[4*m_k +: 4], req_rs1[32*m_k +: 32],
                                     req_rs2[32*m_k +: 32], cyc));
            end
        end
    end

    task automatic set_payload(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[4*k +: 4]   = op;
        req_rs1[32*k +: 32] = a;
        req_rs2[32*k +: 32] = b;
    endtask

    // One operation from requester k with immediate response acceptance; entered at posedge+2.
    task automatic do_op(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] erd, input logic ezr, input logic eerr);
        int n;
        set_payload(k, op, a, b);
        req_valid = onehot(k);
        rsp_ready = '1;
        n = 0;
        @(negedge clk); #1;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("op_grant", 32'(req_ready), 32'(onehot(k)));
        @(posedge clk); #2;
        req_valid = '0;
        @(negedge clk); #1;
        chk("op_exec_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        chk("op_rsp_valid", 32'(rsp_valid), 32'(onehot(k)));
        chk("op_rsp_rd", rsp_rd, erd);
        chk("op_rsp_zr", 32'(rsp_zr), 32'(ezr));
        chk("op_rsp_err", 32'(rsp_err), 32'(eerr));
        @(posedge clk); #2;
    endtask

    initial begin
        int ng, prev, n;
        logic [31:0] ra;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rd", rsp_rd, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #2;

        do_op(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        do_op(1, 4'b1010, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
        do_op(1, 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);

        // Both requesters held valid: grants alternate starting at 0, 3 cycles apart.
        req_valid = '1;
        rsp_ready = '1;
        set_payload(0, 4'b0010, $urandom, $urandom);
        set_payload(1, 4'b0011, $urandom, $urandom);
        ng = 0; prev = 0; n = 0;
        while (ng < 4 && n < 40) begin
            @(negedge clk); #1;
            n++;
            if (req_ready != '0) begin
                chk("alt_grant", 32'(req_ready), 32'(onehot(ng % 2)));
                if (ng > 0) chk("alt_interval", 32'(cyc - prev), 32'd3);
                prev = cyc;
                ng++;
            end
            @(posedge clk); #2;
            if (ng == 4) req_valid = '0;
            set_payload(0, 4'b0010, $urandom, $urandom);
            set_payload(1, 4'b0011, $urandom, $urandom);
        end
        chk("alt_count", 32'(ng), 32'd4);
        repeat (4) @(posedge clk);
        #2;

        // Response stall: requester 0 withholds ready; requester 1's ready bit must be ignored.
        set_payload(0, 4'b0010, 32'd1, 32'd2);
        set_payload(1, 4'b0010, 32'd10, 32'd20);
        req_valid = 2'b01;
        rsp_ready = 2'b10;
        @(negedge clk); #1;
        chk("stall_grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #2;
        req_valid = 2'b10;
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 32'(2'b01));
            chk("stall_rd", rsp_rd, 32'd3);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #2;
        rsp_ready = 2'b01;
        @(negedge clk); #1;
        chk("stall_accept_valid", 32'(rsp_valid), 32'(2'b01));
        @(posedge clk); #2;
        @(negedge clk); #1;
        chk("stall_idle_busy", 32'(busy), 32'd0);
        chk("stall_idle_ready", 32'(req_ready), 32'(2'b10));
        chk("stall_idle_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2;
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) @(posedge clk);
        #2;

        do_op(0, 4'b0110, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1);

        // Reset in EXEC: everything clears, no response follows, requester 0 wins next.
        set_payload(0, 4'b0010, 32'd8, 32'd9);
        req_valid = 2'b01;
        @(negedge clk); #1;
        chk("rstx_grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("rstx_req_ready", 32'(req_ready), 32'd0);
        chk("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstx_rsp_rd", rsp_rd, 32'd0);
        chk("rstx_rsp_zr", 32'(rsp_zr), 32'd0);
        chk("rstx_rsp_err", 32'(rsp_err), 32'd0);
        chk("rstx_alu_op", 32'(alu_op), 32'd0);
        chk("rstx_alu_rs1", alu_rs1, 32'd0);
        chk("rstx_alu_rs2", alu_rs2, 32'd0);
        chk("rstx_busy", 32'(busy), 32'd0);
`ifdef ALU_ARB_PERF_CNT_EN
        chk("rstx_perf_cnt", 32'(perf_cnt), 32'd0);
        chk("rstx_perf_err", 32'(perf_err), 32'd0);
`endif
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rstx_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #2;
        req_valid = 2'b11;
        @(negedge clk); #1;
        chk("rstx_first_grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #2;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #2;

        // Randomized traffic; payload may change while a requester waits.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                req_valid[k] = ($urandom_range(0, 9) < 7);
                rsp_ready[k] = $urandom_range(0, 1) == 1;
                ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                set_payload(k, 4'($urandom_range(0, 15)), ra,
                            ($urandom_range(0, 3) == 0) ? ra : $urandom);
            end
            @(posedge clk); #2;
        end

        req_valid = '0;
        rsp_ready = '1;
        repeat (6) @(posedge clk);
        #2;
        chk("drain_idle", 32'(busy), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
